// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the board UART transmit and receive blocks.
// Holds the receive FSM state encoding, the default bit timing for a 27 MHz
// clock at 115200 baud, and a 3-input majority helper.
package uart_pkg;

   localparam int unsigned UART_CLK_HZ       = 27_000_000;
   localparam int unsigned UART_BAUD         = 115_200;
   // 27e6 / 115200 = 234.375; truncation gives 234 clocks per bit (0.16 % fast)
   localparam int unsigned UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: brings the asynchronous serial line into the clk domain
// through two flops and keeps two further taps of the synchronised line so a
// 3-sample majority vote is available every clock. Configuration macros: none.
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s,
   output logic rx_prev,
   output logic bit_val
);

   logic sync1;
   logic sync2;
   logic tap1;
   logic tap2;

   // Synchroniser and vote history; everything resets to the idle (high) level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         tap1  <= 1'b1;
         tap2  <= 1'b1;
      end else begin
         sync1 <= rx;
         sync2 <= sync1;
         tap1  <= sync2;
         tap2  <= tap1;
      end
   end

   assign rx_s    = sync2;
   assign rx_prev = tap1;
   assign bit_val = majority3(sync2, tap1, tap2);

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial byte receiver with a one-entry valid/ready holding
// register, frame-error and overrun pulses, and a break state that waits for
// the line to return high after a low stop bit.
// Configuration macro: UART_RX_PARITY_EN adds an even-parity bit after the data
// bits and the O_parity_err pulse output.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 I_rst_n,
   input  logic                 I_rx,
   output logic [DATA_BITS-1:0] O_data,
   output logic                 O_valid,
   input  logic                 I_ready,
   output logic                 O_frame_err,
   output logic                 O_overrun,
`ifdef UART_RX_PARITY_EN
   output logic                 O_parity_err,
`endif
   output logic                 O_busy
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
   // The counter is 0 one clock after rx_s fell, and the vote taps lag the
   // counter by 0..2 clocks, so voting here centres the window on the bit middle.
   localparam logic [CW-1:0] CNT_SAMPLE = CW'(CLKS_PER_BIT / 2);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 16) begin : g_bad_clks
      $error("uart_rx_byte: CLKS_PER_BIT must be at least 16");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
      $error("uart_rx_byte: DATA_BITS must be in 5..8");
   end

   uart_state_t          state;
   uart_state_t          state_n;
   logic                 rx_s;
   logic                 rx_prev;
   logic                 bit_val;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 sample;
   logic                 cnt_clr;
   logic                 shift_en;
   logic                 deliver;
   logic                 frame_err_set;
`ifdef UART_RX_PARITY_EN
   logic                 par_chk;
   logic                 par_bad;
   logic                 par_mismatch;
`endif

   uart_rx_sampler u_sampler (
      .clk     (clk),
      .rst_n   (I_rst_n),
      .rx      (I_rx),
      .rx_s    (rx_s),
      .rx_prev (rx_prev),
      .bit_val (bit_val)
   );

   assign sample = (cnt == CNT_SAMPLE);
   assign O_busy = (state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
   assign par_mismatch = (^shreg) ^ bit_val;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!I_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state decode and per-sample control strobes.
   always_comb begin
      state_n       = state;
      cnt_clr       = 1'b0;
      shift_en      = 1'b0;
      deliver       = 1'b0;
      frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_chk       = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (rx_prev && !rx_s) begin
               state_n = ST_START;
            end
         end
         ST_START: begin
            if (sample) begin
               state_n = bit_val ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (sample) begin
               shift_en = 1'b1;
               if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (sample) begin
               par_chk = 1'b1;
               state_n = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (sample) begin
               if (bit_val) begin
`ifdef UART_RX_PARITY_EN
                  deliver = ~par_bad;
`else
                  deliver = 1'b1;
`endif
                  state_n = ST_IDLE;
               end else begin
                  frame_err_set = 1'b1;
                  state_n       = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            cnt_clr = 1'b1;
            if (rx_s) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Bit-period counter: cleared while waiting for an edge, reloaded every bit.
   always_ff @(posedge clk) begin
      if (!I_rst_n || cnt_clr) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Data bit index and LSB-first shift register.
   always_ff @(posedge clk) begin
      if (!I_rst_n) begin
         idx   <= '0;
         shreg <= '0;
      end else begin
         if (cnt_clr) begin
            idx <= '0;
         end else if (shift_en && idx != IDX_LAST) begin
            idx <= idx + 1'b1;
         end
         if (shift_en) begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Remembers a parity mismatch until the stop bit decides delivery.
   always_ff @(posedge clk) begin
      if (!I_rst_n || cnt_clr) begin
         par_bad <= 1'b0;
      end else if (par_chk) begin
         par_bad <= par_mismatch;
      end
   end
`endif

   // Holding register, valid/ready handshake and single-cycle error pulses.
   always_ff @(posedge clk) begin
      if (!I_rst_n) begin
         O_data       <= '0;
         O_valid      <= 1'b0;
         O_frame_err  <= 1'b0;
         O_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         O_parity_err <= 1'b0;
`endif
      end else begin
         O_frame_err  <= frame_err_set;
         O_overrun    <= deliver & O_valid & ~I_ready;
`ifdef UART_RX_PARITY_EN
         O_parity_err <= par_chk & par_mismatch;
`endif
         if (deliver && (!O_valid || I_ready)) begin
            O_data  <= shreg;
            O_valid <= 1'b1;
         end else if (O_valid && I_ready) begin
            O_valid <= 1'b0;
         end
      end
   end

endmodule
